// File: rtl/synth_voice_pkg.sv
// Shared types and constants for the polyphonic voice allocator.
// Provides the note/velocity/amplitude widths, the allocator state enum,
// the latched note-event payload struct and the velocity-to-amplitude mapping.
package synth_voice_pkg;

  localparam int unsigned NOTE_W  = 7;
  localparam int unsigned VEL_W   = 7;
  localparam int unsigned AMP_W   = 16;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned AMP_PAD = AMP_W - VEL_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECIDE = 2'd1,
    GAP    = 2'd2
  } alloc_state_t;

  // Event captured at the handshake edge
  typedef struct packed {
    logic              on;
    logic [NOTE_W-1:0] note;
    logic [VEL_W-1:0]  vel;
  } note_ev_t;

  // Velocity occupies the top bits of the amplitude word
  function automatic logic [AMP_W-1:0] amp_from_vel(input logic [VEL_W-1:0] vel);
    return {vel, AMP_PAD'(0)};
  endfunction

endpackage

// File: rtl/voice_lru.sv
// Least-recently-allocated tracker for the voice allocator.
// Each voice holds a rank; rank 0 is the most recent allocation and
// rank NUM_VOICES-1 is the oldest. Ranks always form a permutation.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   touch_en_i      mark touch_idx_i as most recently allocated
//   touch_idx_i     voice being touched
//   oldest_idx_o    voice currently holding the oldest rank
module voice_lru
  import synth_voice_pkg::*;
#(
  parameter  int unsigned NUM_VOICES = 4,
  localparam int unsigned IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             touch_en_i,
  input  logic [IDX_W-1:0] touch_idx_i,
  output logic [IDX_W-1:0] oldest_idx_o
);

  logic [NUM_VOICES-1:0][IDX_W-1:0] rank_q, rank_d;

  // Touched voice goes to rank 0; everything younger than it ages by one
  always_comb begin
    rank_d = rank_q;
    if (touch_en_i) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (IDX_W'(v) == touch_idx_i) begin
          rank_d[v] = '0;
        end else if (rank_q[v] < rank_q[touch_idx_i]) begin
          rank_d[v] = rank_q[v] + 1'b1;
        end
      end
    end
  end

  // Reset ordering makes the highest-index voice the oldest
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        rank_q[v] <= IDX_W'(v);
      end
    end else begin
      rank_q <= rank_d;
    end
  end

  // Locate the voice holding the oldest rank
  always_comb begin
    oldest_idx_o = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (rank_q[v] == IDX_W'(NUM_VOICES - 1)) begin
        oldest_idx_o = IDX_W'(v);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic note scheduler: shares NUM_VOICES voices between a serial
// stream of note-on/note-off events. Free voices are used first, otherwise
// the least-recently allocated voice is stolen; steals and retriggers hold
// KEY low for RETRIG_CYC cycles so the envelope restarts.
// Optional feature macro: VOICE_ALLOCATOR_SUSTAIN_PEDAL_EN (adds SUSTAIN_PEDAL
// input and per-voice sustain flags).
// Ports:
//   CLK, RESET_N          clock, asynchronous active-low reset
//   EV_VALID/EV_READY     event handshake
//   EV_ON, EV_NOTE, EV_VEL event fields (note-on with velocity 0 is a note-off)
//   ALL_OFF               level-sensitive panic: drops every gate
//   SUSTAIN_PEDAL         sustain pedal level (feature build only)
//   KEY                   per-voice gate
//   FREQ                  per-voice note, voice v at [7v+6:7v]
//   AMP                   per-voice amplitude, voice v at [16v+15:16v]
//   STEAL_CNT             saturating count of voice steals
//   BUSY                  allocator is not idle
module voice_allocator
  import synth_voice_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned RETRIG_CYC = 4
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic                         EV_VALID,
  output logic                         EV_READY,
  input  logic                         EV_ON,
  input  logic [NOTE_W-1:0]            EV_NOTE,
  input  logic [VEL_W-1:0]             EV_VEL,
  input  logic                         ALL_OFF,
`ifdef VOICE_ALLOCATOR_SUSTAIN_PEDAL_EN
  input  logic                         SUSTAIN_PEDAL,
`endif
  output logic [NUM_VOICES-1:0]        KEY,
  output logic [NUM_VOICES*NOTE_W-1:0] FREQ,
  output logic [NUM_VOICES*AMP_W-1:0]  AMP,
  output logic [CNT_W-1:0]             STEAL_CNT,
  output logic                         BUSY
);

  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned GAP_W = (RETRIG_CYC > 1) ? $clog2(RETRIG_CYC) : 1;

  alloc_state_t state_q, state_d;

  note_ev_t                          ev_q, ev_d;
  logic [NUM_VOICES-1:0]             key_q, key_d;
  logic [NUM_VOICES-1:0][NOTE_W-1:0] freq_q, freq_d;
  logic [NUM_VOICES-1:0][AMP_W-1:0]  amp_q, amp_d;
  logic [CNT_W-1:0]                  steal_q, steal_d;
  logic [GAP_W-1:0]                  gap_q, gap_d;
  logic [IDX_W-1:0]                  tgt_q, tgt_d;

  logic                  accept;
  logic                  is_on;
  logic                  hit_found, free_found;
  logic [IDX_W-1:0]      hit_idx, free_idx;
  logic [NUM_VOICES-1:0] match;
  logic                  touch_en;
  logic [IDX_W-1:0]      touch_idx;
  logic [IDX_W-1:0]      oldest_idx;

`ifdef VOICE_ALLOCATOR_SUSTAIN_PEDAL_EN
  logic [NUM_VOICES-1:0] sus_q, sus_d;
  logic                  pedal_q;
  logic                  pedal_fall;
`endif

  assign EV_READY = (state_q == IDLE) & ~ALL_OFF;
  assign accept   = EV_VALID & EV_READY;
  // Velocity 0 turns a note-on into a note-off
  assign is_on    = ev_q.on & (ev_q.vel != '0);

  // Voice scan: match mask, lowest sounding hit and lowest free voice
  always_comb begin
    match      = '0;
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      match[v] = key_q[v] & (freq_q[v] == ev_q.note);
      if (match[v]) begin
        hit_found = 1'b1;
        hit_idx   = IDX_W'(v);
      end
      if (!key_q[v]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(v);
      end
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; panic overrides everything
  always_comb begin
    state_d = state_q;
    if (ALL_OFF) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = DECIDE;
        DECIDE:  state_d = (is_on && (hit_found || !free_found)) ? GAP : IDLE;
        GAP:     if (gap_q == '0) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output / datapath next-values
  always_comb begin
    ev_d      = ev_q;
    key_d     = key_q;
    freq_d    = freq_q;
    amp_d     = amp_q;
    steal_d   = steal_q;
    gap_d     = gap_q;
    tgt_d     = tgt_q;
    touch_en  = 1'b0;
    touch_idx = tgt_q;
`ifdef VOICE_ALLOCATOR_SUSTAIN_PEDAL_EN
    sus_d     = sus_q;
`endif
    if (ALL_OFF) begin
      key_d = '0;
`ifdef VOICE_ALLOCATOR_SUSTAIN_PEDAL_EN
      sus_d = '0;
`endif
    end else begin
`ifdef VOICE_ALLOCATOR_SUSTAIN_PEDAL_EN
      // Pedal release applied first so a same-cycle DECIDE action wins
      if (pedal_fall) begin
        key_d = key_q & ~sus_q;
        sus_d = '0;
      end
`endif
      case (state_q)
        IDLE: begin
          if (accept) begin
            ev_d.on   = EV_ON;
            ev_d.note = EV_NOTE;
            ev_d.vel  = EV_VEL;
          end
        end
        DECIDE: begin
          if (is_on) begin
            if (hit_found) begin
              // Retrigger the sounding voice
              tgt_d          = hit_idx;
              key_d[hit_idx] = 1'b0;
              amp_d[hit_idx] = amp_from_vel(ev_q.vel);
              gap_d          = GAP_W'(RETRIG_CYC - 1);
`ifdef VOICE_ALLOCATOR_SUSTAIN_PEDAL_EN
              sus_d[hit_idx] = 1'b0;
`endif
            end else if (free_found) begin
              freq_d[free_idx] = ev_q.note;
              amp_d[free_idx]  = amp_from_vel(ev_q.vel);
              key_d[free_idx]  = 1'b1;
              touch_en         = 1'b1;
              touch_idx        = free_idx;
            end else begin
              // Steal the oldest voice; a stolen voice starts a fresh note
              tgt_d             = oldest_idx;
              key_d[oldest_idx] = 1'b0;
              freq_d[oldest_idx] = ev_q.note;
              amp_d[oldest_idx] = amp_from_vel(ev_q.vel);
              gap_d             = GAP_W'(RETRIG_CYC - 1);
              if (steal_q != '1) steal_d = steal_q + 1'b1;
`ifdef VOICE_ALLOCATOR_SUSTAIN_PEDAL_EN
              sus_d[oldest_idx] = 1'b0;
`endif
            end
          end else begin
`ifdef VOICE_ALLOCATOR_SUSTAIN_PEDAL_EN
            if (SUSTAIN_PEDAL) begin
              sus_d = sus_d | match;
            end else begin
              key_d = key_d & ~match;
            end
`else
            key_d = key_d & ~match;
`endif
          end
        end
        GAP: begin
          if (gap_q == '0) begin
            key_d[tgt_q] = 1'b1;
            touch_en     = 1'b1;
            touch_idx    = tgt_q;
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ev_q    <= '0;
      key_q   <= '0;
      freq_q  <= '0;
      amp_q   <= '0;
      steal_q <= '0;
      gap_q   <= '0;
      tgt_q   <= '0;
    end else begin
      ev_q    <= ev_d;
      key_q   <= key_d;
      freq_q  <= freq_d;
      amp_q   <= amp_d;
      steal_q <= steal_d;
      gap_q   <= gap_d;
      tgt_q   <= tgt_d;
    end
  end

`ifdef VOICE_ALLOCATOR_SUSTAIN_PEDAL_EN
  assign pedal_fall = pedal_q & ~SUSTAIN_PEDAL;

  // Sustain flags and pedal history for falling-edge detection
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sus_q   <= '0;
      pedal_q <= 1'b0;
    end else begin
      sus_q   <= sus_d;
      pedal_q <= SUSTAIN_PEDAL;
    end
  end
`endif

  voice_lru #(
    .NUM_VOICES(NUM_VOICES)
  ) u_lru (
    .clk_i       (CLK),
    .rst_ni      (RESET_N),
    .touch_en_i  (touch_en),
    .touch_idx_i (touch_idx),
    .oldest_idx_o(oldest_idx)
  );

  assign KEY       = key_q;
  assign FREQ      = freq_q;
  assign AMP       = amp_q;
  assign STEAL_CNT = steal_q;
  assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_voice_allocator.sv
// Directed self-checking bench for voice_allocator (NUM_VOICES=4, RETRIG_CYC=4).
module tb_voice_allocator;

  logic        CLK;
  logic        RESET_N;
  logic        EV_VALID;
  logic        EV_READY;
  logic        EV_ON;
  logic [6:0]  EV_NOTE;
  logic [6:0]  EV_VEL;
  logic        ALL_OFF;
`ifdef VOICE_ALLOCATOR_SUSTAIN_PEDAL_EN
  logic        SUSTAIN_PEDAL;
`endif
  logic [3:0]  KEY;
  logic [27:0] FREQ;
  logic [63:0] AMP;
  logic [15:0] STEAL_CNT;
  logic        BUSY;

  int tests = 0;
  int fails = 0;

  voice_allocator #(
    .NUM_VOICES(4),
    .RETRIG_CYC(4)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .EV_VALID (EV_VALID),
    .EV_READY (EV_READY),
    .EV_ON    (EV_ON),
    .EV_NOTE  (EV_NOTE),
    .EV_VEL   (EV_VEL),
    .ALL_OFF  (ALL_OFF),
`ifdef VOICE_ALLOCATOR_SUSTAIN_PEDAL_EN
    .SUSTAIN_PEDAL(SUSTAIN_PEDAL),
`endif
    .KEY      (KEY),
    .FREQ     (FREQ),
    .AMP      (AMP),
    .STEAL_CNT(STEAL_CNT),
    .BUSY     (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Present an event and return 1ns after the handshake edge
  task automatic send(input logic on, input logic [6:0] note, input logic [6:0] vel);
    logic done;
    done     = 1'b0;
    EV_ON    = on;
    EV_NOTE  = note;
    EV_VEL   = vel;
    EV_VALID = 1'b1;
    for (int i = 0; i < 32 && !done; i++) begin
      done = EV_READY;
      @(posedge CLK);
      #1;
    end
    EV_VALID = 1'b0;
    tests++;
    assert (done === 1'b1) else begin
      fails++;
      $error("FAIL handshake_timeout: observed %0b expected 1", done);
    end
  endtask

  initial begin
    RESET_N  = 1'b0;
    EV_VALID = 1'b0;
    EV_ON    = 1'b0;
    EV_NOTE  = '0;
    EV_VEL   = '0;
    ALL_OFF  = 1'b0;
`ifdef VOICE_ALLOCATOR_SUSTAIN_PEDAL_EN
    SUSTAIN_PEDAL = 1'b0;
`endif
    #12;
    check("rst_key",   64'(KEY), 64'h0);
    check("rst_freq",  64'(FREQ), 64'h0);
    check("rst_amp",   AMP, 64'h0);
    check("rst_steal", 64'(STEAL_CNT), 64'h0);
    check("rst_busy",  64'(BUSY), 64'h0);
    check("rst_ready", 64'(EV_READY), 64'h1);
    RESET_N = 1'b1;
    tick(1);

    // Free allocation into voice 0
    send(1'b1, 7'd60, 7'd100);
    check("alloc_lat_key",  64'(KEY), 64'h0);
    check("alloc_busy",     64'(BUSY), 64'h1);
    check("alloc_notready", 64'(EV_READY), 64'h0);
    tick(1);
    check("alloc_key",   64'(KEY), 64'h1);
    check("alloc_freq0", 64'(FREQ[6:0]), 64'd60);
    check("alloc_amp0",  64'(AMP[15:0]), 64'hC800);
    check("alloc_ready", 64'(EV_READY), 64'h1);
    check("alloc_idle",  64'(BUSY), 64'h0);

    // Fill remaining voices
    send(1'b1, 7'd62, 7'd64); tick(1);
    check("fill1_key", 64'(KEY), 64'h3);
    send(1'b1, 7'd64, 7'd32); tick(1);
    check("fill2_key", 64'(KEY), 64'h7);
    send(1'b1, 7'd65, 7'd16); tick(1);
    check("fill3_key", 64'(KEY), 64'hF);
    check("fill_freq", 64'(FREQ), 64'({7'd65, 7'd64, 7'd62, 7'd60}));

    // Steal: oldest is voice 0
    send(1'b1, 7'd67, 7'd127);
    check("steal_lat_key", 64'(KEY), 64'hF);
    tick(1);
    check("steal_key_low", 64'(KEY), 64'hE);
    check("steal_freq0",   64'(FREQ[6:0]), 64'd67);
    check("steal_amp0",    64'(AMP[15:0]), 64'hFE00);
    check("steal_cnt1",    64'(STEAL_CNT), 64'd1);
    check("steal_busy",    64'(BUSY), 64'h1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("steal_gap_low", 64'(KEY), 64'hE);
    end
    tick(1);
    check("steal_key_high", 64'(KEY), 64'hF);
    check("steal_done_idle", 64'(BUSY), 64'h0);

    // Retrigger held note 62 on voice 1
    send(1'b1, 7'd62, 7'd10);
    tick(1);
    check("retrig_key_low", 64'(KEY), 64'hD);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("retrig_gap_low", 64'(KEY), 64'hD);
    end
    tick(1);
    check("retrig_key_high", 64'(KEY), 64'hF);
    check("retrig_steal",    64'(STEAL_CNT), 64'd1);
    check("retrig_freq",     64'(FREQ), 64'({7'd65, 7'd64, 7'd62, 7'd67}));
    check("retrig_amp",      AMP, {16'h2000, 16'h4000, 16'h1400, 16'hFE00});

    // Note-offs
    send(1'b0, 7'd64, 7'd0); tick(1);
    check("off64_key",  64'(KEY), 64'hB);
    check("off64_freq", 64'(FREQ[20:14]), 64'd64);
    send(1'b0, 7'd50, 7'd0); tick(1);
    check("off50_key",  64'(KEY), 64'hB);
    send(1'b1, 7'd65, 7'd0); tick(1);
    check("vel0_key",   64'(KEY), 64'h3);
    check("vel0_freq",  64'(FREQ), 64'({7'd65, 7'd64, 7'd62, 7'd67}));
    check("vel0_amp3",  64'(AMP[63:48]), 64'h2000);

    // Lowest free voice first
    send(1'b1, 7'd72, 7'd1); tick(1);
    check("free2_key",  64'(KEY), 64'h7);
    check("free2_freq", 64'(FREQ[20:14]), 64'd72);
    check("free2_amp",  64'(AMP[47:32]), 64'h0200);
    send(1'b1, 7'd74, 7'd2); tick(1);
    check("free3_key",  64'(KEY), 64'hF);

    // Steal voice 0 then panic during the gap
    send(1'b1, 7'd76, 7'd3); tick(1);
    check("steal2_key", 64'(KEY), 64'hE);
    check("steal2_cnt", 64'(STEAL_CNT), 64'd2);
    tick(1);
    ALL_OFF = 1'b1;
    #1;
    check("panic_ready_low", 64'(EV_READY), 64'h0);
    tick(1);
    check("panic_key",   64'(KEY), 64'h0);
    check("panic_busy",  64'(BUSY), 64'h0);
    check("panic_ready", 64'(EV_READY), 64'h0);
    check("panic_freq0", 64'(FREQ[6:0]), 64'd76);
    check("panic_steal", 64'(STEAL_CNT), 64'd2);
    tick(1);
    ALL_OFF = 1'b0;
    #1;
    check("post_panic_ready", 64'(EV_READY), 64'h1);
    send(1'b1, 7'd60, 7'd100); tick(1);
    check("post_panic_key", 64'(KEY), 64'h1);
    check("post_panic_freq", 64'(FREQ[6:0]), 64'd60);
    tick(6);
    check("post_panic_stable", 64'(KEY), 64'h1);

    // Reset asserted mid-gap
    send(1'b1, 7'd61, 7'd5); tick(1);
    send(1'b1, 7'd63, 7'd5); tick(1);
    send(1'b1, 7'd66, 7'd5); tick(1);
    check("refill_key", 64'(KEY), 64'hF);
    send(1'b1, 7'd68, 7'd5); tick(1);
    check("steal3_key", 64'(KEY), 64'hE);
    check("steal3_cnt", 64'(STEAL_CNT), 64'd3);
    RESET_N = 1'b0;
    #1;
    check("midrst_key",   64'(KEY), 64'h0);
    check("midrst_freq",  64'(FREQ), 64'h0);
    check("midrst_amp",   AMP, 64'h0);
    check("midrst_steal", 64'(STEAL_CNT), 64'h0);
    check("midrst_busy",  64'(BUSY), 64'h0);
    #6;
    RESET_N = 1'b1;
    tick(6);
    check("midrst_after", 64'(KEY), 64'h0);

`ifdef VOICE_ALLOCATOR_SUSTAIN_PEDAL_EN
    // Sustain pedal holds a released note until the pedal falls
    SUSTAIN_PEDAL = 1'b1;
    tick(1);
    send(1'b1, 7'd60, 7'd100); tick(1);
    check("sus_on_key", 64'(KEY), 64'h1);
    send(1'b0, 7'd60, 7'd0); tick(1);
    check("sus_held_key", 64'(KEY), 64'h1);
    SUSTAIN_PEDAL = 1'b0;
    #1;
    check("sus_pre_fall", 64'(KEY), 64'h1);
    tick(1);
    check("sus_release", 64'(KEY), 64'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
